bitmap_slot_allocator: RTL and testbench



---
 rtl/bitmap_slot_allocator_if.sv | 18 +
 rtl/bitmap_slot_allocator.sv | 55 +++++
 tb/tb_bitmap_slot_allocator.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/bitmap_slot_allocator_if.sv
// bitmap_slot_allocator_if: slot allocation and release handshakes
interface bitmap_slot_allocator_if #(parameter int INDEX_WIDTH = 3);
    logic                   alloc_valid;
    logic                   alloc_ready;
    logic [INDEX_WIDTH-1:0] alloc_index;
    logic                   free_valid;
    logic                   free_ready;
    logic [INDEX_WIDTH-1:0] free_index;
    logic                   free_error;
    modport master (
        input  alloc_valid, alloc_index, free_ready, free_error,
        output alloc_ready, free_valid, free_index
    );
    modport slave (
        output alloc_valid, alloc_index, free_ready, free_error,
        input  alloc_ready, free_valid, free_index
    );
endinterface

// File: rtl/bitmap_slot_allocator.sv
// bitmap_slot_allocator: hands out the lowest free slot index and recycles released ones
module bitmap_slot_allocator #(
    parameter int SLOT_COUNT  = 8,
    parameter int INDEX_WIDTH = 3,
    parameter int COUNT_WIDTH = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    bitmap_slot_allocator_if.slave bus,
    output logic [SLOT_COUNT-1:0]  slot_map,
    output logic [COUNT_WIDTH-1:0] occupancy,
    output logic                   full,
    output logic                   empty
);
    logic                   loadable;
    logic                   free_ok;
    logic [INDEX_WIDTH-1:0] pick;
    logic [SLOT_COUNT-1:0]  reserve_mask;
    logic [SLOT_COUNT-1:0]  free_mask;
    assign full          = &slot_map;
    assign empty         = ~|slot_map;
    assign bus.free_ready = 1'b1;
    assign loadable      = ~bus.alloc_valid | bus.alloc_ready;
    assign reserve_mask  = (loadable && !full) ? (SLOT_COUNT'(1) << pick) : '0;
    // an out-of-range index shifts the one off the top, so it never matches a set bit
    assign free_mask     = SLOT_COUNT'(1) << bus.free_index;
    assign free_ok       = bus.free_valid && |(slot_map & free_mask) &&
                           !(bus.alloc_valid && bus.free_index == bus.alloc_index);
    // lowest clear bit of the registered bitmap
    always_comb begin
        pick = '0;
        for (int i = SLOT_COUNT - 1; i >= 0; i--) pick = slot_map[i] ? pick : INDEX_WIDTH'(i);
    end
    // population count of the bitmap
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < SLOT_COUNT; i++) occupancy = occupancy + COUNT_WIDTH'(slot_map[i]);
    end
    // reserve into the holding register and apply releases at the same edge
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            slot_map        <= '0;
            bus.alloc_valid <= 1'b0;
            bus.alloc_index <= '0;
            bus.free_error  <= 1'b0;
        end else begin
            slot_map       <= (slot_map | reserve_mask) & ~(free_ok ? free_mask : '0);
            bus.free_error <= bus.free_valid & ~free_ok;
            if (loadable) begin
                bus.alloc_valid <= ~full;
                if (!full) bus.alloc_index <= pick;
            end
        end
    end
endmodule

// File: tb/tb_bitmap_slot_allocator.sv
// tb_bitmap_slot_allocator: directed and randomized checks against a slot-set model
module tb_bitmap_slot_allocator;
    localparam int N = 8;
    logic clock = 0;
    logic reset_n = 0;
    logic [N-1:0] slot_map;
    logic [3:0] occupancy;
    logic full, empty;
    int total = 0;
    int bad = 0;
    bit used[N];
    bit m_valid;
    int m_idx;
    bit m_err;

    bitmap_slot_allocator_if #(.INDEX_WIDTH(3)) bus();

    bitmap_slot_allocator #(.SLOT_COUNT(N), .INDEX_WIDTH(3), .COUNT_WIDTH(4)) dut (
        .clock(clock), .reset_n(reset_n), .bus(bus),
        .slot_map(slot_map), .occupancy(occupancy), .full(full), .empty(empty)
    );

    always #5 clock = ~clock;

    function automatic logic [N-1:0] m_map();
        logic [N-1:0] v = '0;
        for (int i = 0; i < N; i++) if (used[i]) v = v | (N'(1) << i);
        return v;
    endfunction

    function automatic int m_count();
        int c = 0;
        foreach (used[i]) c += used[i];
        return c;
    endfunction

    function automatic int lowest_free();
        for (int i = 0; i < N; i++) if (!used[i]) return i;
        return -1;
    endfunction

    function automatic void m_reset();
        foreach (used[i]) used[i] = 0;
        m_valid = 0;
        m_idx = 0;
        m_err = 0;
    endfunction

    task automatic cycle();
        bit ready = bus.alloc_ready;
        bit fv = bus.free_valid;
        int fi = int'(bus.free_index);
        bit ld = !m_valid || ready;
        int p = lowest_free();
        bit fok = fv && fi < N && used[fi] && !(m_valid && fi == m_idx);
        @(posedge clock);
        #1;
        if (ld) begin
            if (p >= 0) begin
                used[p] = 1;
                m_idx = p;
                m_valid = 1;
            end else m_valid = 0;
        end
        if (fok) used[fi] = 0;
        m_err = fv && !fok;
    endtask

    task automatic test_reset();
        bus.alloc_ready = 0;
        bus.free_valid = 0;
        bus.free_index = 0;
        reset_n = 0;
        m_reset();
        repeat (2) @(posedge clock);
        #1;
        total++; if (slot_map !== 8'h00) begin bad++; $display("FAIL reset_map got %h want 00", slot_map); end
        total++; if (bus.alloc_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", bus.alloc_valid); end
        total++; if (bus.alloc_index !== 3'd0) begin bad++; $display("FAIL reset_index got %0d want 0", bus.alloc_index); end
        total++; if (bus.free_error !== 1'b0) begin bad++; $display("FAIL reset_err got %b want 0", bus.free_error); end
        total++; if (occupancy !== 4'd0) begin bad++; $display("FAIL reset_occ got %0d want 0", occupancy); end
        total++; if (full !== 1'b0 || empty !== 1'b1) begin bad++; $display("FAIL reset_flags got full=%b empty=%b want 0 1", full, empty); end
        total++; if (bus.free_ready !== 1'b1) begin bad++; $display("FAIL free_ready got %b want 1", bus.free_ready); end
        reset_n = 1;
    endtask

    task automatic test_alloc_seq();
        cycle();
        total++; if (bus.alloc_valid !== 1'b1 || bus.alloc_index !== 3'd0) begin bad++; $display("FAIL first_offer got v=%b i=%0d want 1 0", bus.alloc_valid, bus.alloc_index); end
        bus.alloc_ready = 1;
        for (int k = 1; k <= 4; k++) begin
            cycle();
            total++; if (bus.alloc_index !== 3'(k) || bus.alloc_valid !== 1'b1) begin bad++; $display("FAIL seq_index%0d got v=%b i=%0d want 1 %0d", k, bus.alloc_valid, bus.alloc_index, k); end
        end
        bus.alloc_ready = 0;
        total++; if (occupancy !== 4'd5 || slot_map !== 8'h1F) begin bad++; $display("FAIL seq_state got occ=%0d map=%h want 5 1f", occupancy, slot_map); end
    endtask

    task automatic test_free_while_offered();
        bus.free_valid = 1;
        bus.free_index = 1;
        cycle();
        bus.free_valid = 0;
        total++; if (slot_map !== 8'h1D || bus.free_error !== 1'b0) begin bad++; $display("FAIL free1_map got %h err=%b want 1d 0", slot_map, bus.free_error); end
        total++; if (bus.alloc_index !== 3'd4 || bus.alloc_valid !== 1'b1) begin bad++; $display("FAIL hold_offer got v=%b i=%0d want 1 4", bus.alloc_valid, bus.alloc_index); end
        bus.alloc_ready = 1;
        cycle();
        bus.alloc_ready = 0;
        total++; if (bus.alloc_index !== 3'd1 || slot_map !== 8'h1F) begin bad++; $display("FAIL reuse1 got i=%0d map=%h want 1 1f", bus.alloc_index, slot_map); end
    endtask

    task automatic test_full();
        int budget = 20;
        bus.alloc_ready = 1;
        while (!(m_count() == N && !m_valid) && budget > 0) begin
            cycle();
            budget--;
        end
        bus.alloc_ready = 0;
        total++; if (budget == 0) begin bad++; $display("FAIL fill_budget got expired want full"); end
        total++; if (full !== 1'b1 || bus.alloc_valid !== 1'b0 || occupancy !== 4'd8) begin bad++; $display("FAIL full_state got full=%b v=%b occ=%0d want 1 0 8", full, bus.alloc_valid, occupancy); end
        bus.free_valid = 1;
        bus.free_index = 5;
        cycle();
        bus.free_valid = 0;
        total++; if (full !== 1'b0 || bus.alloc_valid !== 1'b0 || slot_map !== 8'hDF) begin bad++; $display("FAIL after_free5 got full=%b v=%b map=%h want 0 0 df", full, bus.alloc_valid, slot_map); end
        cycle();
        total++; if (bus.alloc_valid !== 1'b1 || bus.alloc_index !== 3'd5 || full !== 1'b1) begin bad++; $display("FAIL reoffer5 got v=%b i=%0d full=%b want 1 5 1", bus.alloc_valid, bus.alloc_index, full); end
    endtask

    task automatic test_illegal_free();
        bus.free_valid = 1;
        bus.free_index = 6;
        cycle();
        total++; if (slot_map !== 8'hBF || bus.free_error !== 1'b0) begin bad++; $display("FAIL legal6 got map=%h err=%b want bf 0", slot_map, bus.free_error); end
        cycle();
        total++; if (slot_map !== 8'hBF || bus.free_error !== 1'b1) begin bad++; $display("FAIL double6 got map=%h err=%b want bf 1", slot_map, bus.free_error); end
        bus.free_index = 5;
        cycle();
        bus.free_valid = 0;
        total++; if (slot_map !== 8'hBF || bus.free_error !== 1'b1) begin bad++; $display("FAIL offered5 got map=%h err=%b want bf 1", slot_map, bus.free_error); end
        cycle();
        total++; if (bus.free_error !== 1'b0 || bus.alloc_index !== 3'd5) begin bad++; $display("FAIL err_drop got err=%b i=%0d want 0 5", bus.free_error, bus.alloc_index); end
    endtask

    task automatic test_same_cycle();
        reset_n = 0;
        m_reset();
        @(posedge clock);
        #2;
        reset_n = 1;
        cycle();
        bus.alloc_ready = 1;
        repeat (3) cycle();
        total++; if (slot_map !== 8'h0F || bus.alloc_index !== 3'd3) begin bad++; $display("FAIL setup got map=%h i=%0d want 0f 3", slot_map, bus.alloc_index); end
        bus.free_valid = 1;
        bus.free_index = 0;
        cycle();
        bus.free_valid = 0;
        total++; if (bus.alloc_index !== 3'd4 || slot_map !== 8'h1E) begin bad++; $display("FAIL no_reuse got i=%0d map=%h want 4 1e", bus.alloc_index, slot_map); end
        cycle();
        bus.alloc_ready = 0;
        total++; if (bus.alloc_index !== 3'd0 || slot_map !== 8'h1F) begin bad++; $display("FAIL reuse0 got i=%0d map=%h want 0 1f", bus.alloc_index, slot_map); end
    endtask

    task automatic test_mid_reset();
        bus.alloc_ready = 1;
        repeat (3) cycle();
        #3;
        reset_n = 0;
        #1;
        m_reset();
        total++; if (slot_map !== 8'h00 || bus.alloc_valid !== 1'b0 || empty !== 1'b1) begin bad++; $display("FAIL async_reset got map=%h v=%b empty=%b want 00 0 1", slot_map, bus.alloc_valid, empty); end
        @(posedge clock);
        #2;
        reset_n = 1;
        cycle();
        bus.alloc_ready = 0;
        total++; if (bus.alloc_valid !== 1'b1 || bus.alloc_index !== 3'd0) begin bad++; $display("FAIL post_reset got v=%b i=%0d want 1 0", bus.alloc_valid, bus.alloc_index); end
    endtask

    task automatic test_random();
        int errs = 0;
        for (int k = 0; k < 400; k++) begin
            bus.alloc_ready = 1'($urandom % 2);
            bus.free_valid = ($urandom % 3) != 0;
            bus.free_index = 3'($urandom_range(0, N - 1));
            cycle();
            total++;
            if (slot_map !== m_map() || bus.alloc_valid !== m_valid || bus.alloc_index !== 3'(m_idx) ||
                bus.free_error !== m_err || occupancy !== 4'(m_count()) ||
                full !== (m_count() == N) || empty !== (m_count() == 0)) begin
                bad++;
                if (errs++ < 10)
                    $display("FAIL random%0d got map=%h v=%b i=%0d err=%b occ=%0d want map=%h v=%b i=%0d err=%b occ=%0d",
                             k, slot_map, bus.alloc_valid, bus.alloc_index, bus.free_error, occupancy,
                             m_map(), m_valid, m_idx, m_err, m_count());
            end
        end
        bus.alloc_ready = 0;
        bus.free_valid = 0;
    endtask

    initial begin
        test_reset();
        test_alloc_seq();
        test_free_while_offered();
        test_full();
        test_illegal_free();
        test_same_cycle();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
